// File: rtl/taillight_seq_dwe_pkg.sv
// Shared constants for the tail-light sequencer: one-hot state bit positions,
// the state width, the default step divider and the state encoding.
package taillight_seq_dwe_pkg;

  localparam int STATE_W      = 7;
  localparam int TICK_DIV_DEF = 25000000;

  localparam int IDX_S0 = 0;
  localparam int IDX_S1 = 1;
  localparam int IDX_S2 = 2;
  localparam int IDX_S3 = 3;
  localparam int IDX_S4 = 4;
  localparam int IDX_S5 = 5;
  localparam int IDX_S6 = 6;

  typedef enum logic [STATE_W-1:0] {
    ST_S0 = 7'b1 << IDX_S0,
    ST_S1 = 7'b1 << IDX_S1,
    ST_S2 = 7'b1 << IDX_S2,
    ST_S3 = 7'b1 << IDX_S3,
    ST_S4 = 7'b1 << IDX_S4,
    ST_S5 = 7'b1 << IDX_S5,
    ST_S6 = 7'b1 << IDX_S6
  } state_e;

endpackage

// File: rtl/taillight_tick_dwe.sv
// Step strobe generator: free-running 0..TICK_DIV-1 counter, TICK high on the
// last count so every step lasts exactly TICK_DIV cycles.
module taillight_tick_dwe
  import taillight_seq_dwe_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLK,
  input  logic RESET_N,
  output logic TICK
);

  localparam int              CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign TICK  = (cnt_q == LAST);
  assign cnt_d = TICK ? '0 : cnt_q + CNT_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/taillight_seq_dwe.sv
// Tail-light sequencer: synchronizes the turn switches and steps a one-hot
// left/right/hazard FSM once per TICK.
module taillight_seq_dwe
  import taillight_seq_dwe_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic LEFT,
  input  logic RIGHT,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic S4,
  output logic S5,
  output logic S6,
  output logic TICK
);

  logic   ls_meta_q, ls_q;
  logic   rs_meta_q, rs_q;
  state_e state_q, state_d;
  logic   hazard;

  taillight_tick_dwe #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .TICK    (TICK)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      ls_meta_q <= 1'b0;
      ls_q      <= 1'b0;
      rs_meta_q <= 1'b0;
      rs_q      <= 1'b0;
      state_q   <= ST_S0;
    end else begin
      ls_meta_q <= LEFT;
      ls_q      <= ls_meta_q;
      rs_meta_q <= RIGHT;
      rs_q      <= rs_meta_q;
      state_q   <= state_d;
    end
  end

  assign hazard = ls_q && rs_q;

  // NOTE: state_d gets its hold value first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_S0: if (TICK) begin
        if (hazard)    state_d = ST_S3;
        else if (ls_q) state_d = ST_S1;
        else if (rs_q) state_d = ST_S4;
      end
      ST_S1: if (TICK) state_d = ST_S2;
      ST_S2: if (TICK) state_d = ST_S3;
      ST_S3: if (TICK) state_d = hazard ? ST_S6 : ST_S0;
      ST_S4: if (TICK) state_d = ST_S5;
      ST_S5: if (TICK) state_d = ST_S6;
      ST_S6: if (TICK) state_d = hazard ? ST_S3 : ST_S0;
      // Any corrupted (non-one-hot) value recovers immediately, tick or not.
      default: state_d = ST_S0;
    endcase
  end

  assign S0 = state_q[IDX_S0];
  assign S1 = state_q[IDX_S1];
  assign S2 = state_q[IDX_S2];
  assign S3 = state_q[IDX_S3];
  assign S4 = state_q[IDX_S4];
  assign S5 = state_q[IDX_S5];
  assign S6 = state_q[IDX_S6];

endmodule
